// File: rtl/cmp_result_monitor_if.sv
// cmp_result_monitor_if
//   Groups the comparator-sample inputs and the monitor result outputs of
//   cmp_result_monitor. clk/rst are not part of the bundle.
//   Ports (signals):
//     en, clr, sample          control from the sweep controller
//     f1, f2, f3               comparator A>B, A==B, A<B flags
//     gt_cnt, eq_cnt, lt_cnt   per-class saturating tallies (CNT_W bits)
//     run_len, run_flag        current run length and its threshold flag
//     err, busy                non-one-hot fault flag, monitor running
//   Modports: master drives the inputs, slave is the monitor itself.
interface cmp_result_monitor_if #(
    parameter int unsigned CNT_W = 8
);
    logic             en;
    logic             clr;
    logic             sample;
    logic             f1;
    logic             f2;
    logic             f3;
    logic [CNT_W-1:0] gt_cnt;
    logic [CNT_W-1:0] eq_cnt;
    logic [CNT_W-1:0] lt_cnt;
    logic [CNT_W-1:0] run_len;
    logic             run_flag;
    logic             err;
    logic             busy;

    modport master (
        output en, clr, sample, f1, f2, f3,
        input  gt_cnt, eq_cnt, lt_cnt, run_len, run_flag, err, busy
    );

    modport slave (
        input  en, clr, sample, f1, f2, f3,
        output gt_cnt, eq_cnt, lt_cnt, run_len, run_flag, err, busy
    );
endinterface

// File: rtl/cmp_result_monitor.sv
// cmp_result_monitor
//   Registers the 2-bit magnitude comparator's greater/equal/less flags on
//   each sample strobe, keeps saturating tallies per result class, tracks the
//   length of the current run of identical results and latches a fault when a
//   non-one-hot pattern is sampled.
//   Ports:
//     clk   rising-edge clock
//     rst   synchronous active-high reset
//     bus   cmp_result_monitor_if.slave (en, clr, sample, f1..f3 in;
//           gt/eq/lt counts, run_len, run_flag, err, busy out)
module cmp_result_monitor #(
    parameter int unsigned CNT_W  = 8,
    parameter int unsigned RUN_TH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    cmp_result_monitor_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_ERR  = 2'b10
    } state_t;

    typedef enum logic [1:0] {
        CLS_NONE = 2'b00,
        CLS_GT   = 2'b01,
        CLS_EQ   = 2'b10,
        CLS_LT   = 2'b11
    } cls_t;

    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [CNT_W-1:0] RUN_TH_C = CNT_W'(RUN_TH);

    state_t           r_state;
    cls_t             r_last;
    logic [CNT_W-1:0] r_gt_cnt;
    logic [CNT_W-1:0] r_eq_cnt;
    logic [CNT_W-1:0] r_lt_cnt;
    logic [CNT_W-1:0] r_run_len;
    logic             r_err;
    logic             r_busy;

    logic [2:0]       w_pattern;
    logic             w_onehot;
    cls_t             w_cls;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + CNT_W'(1);
    endfunction

    assign w_pattern = {bus.f1, bus.f2, bus.f3};

    always_comb begin
        w_onehot = 1'b0;
        w_cls    = CLS_NONE;
        case (w_pattern)
            3'b100: begin w_onehot = 1'b1; w_cls = CLS_GT; end
            3'b010: begin w_onehot = 1'b1; w_cls = CLS_EQ; end
            3'b001: begin w_onehot = 1'b1; w_cls = CLS_LT; end
            default: begin w_onehot = 1'b0; w_cls = CLS_NONE; end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst || bus.clr) begin
            r_state   <= ST_IDLE;
            r_last    <= CLS_NONE;
            r_gt_cnt  <= '0;
            r_eq_cnt  <= '0;
            r_lt_cnt  <= '0;
            r_run_len <= '0;
            r_err     <= 1'b0;
            r_busy    <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    // The sample coincident with entering RUN is dropped.
                    if (bus.en) begin
                        r_state <= ST_RUN;
                        r_busy  <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (!bus.en) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end else if (bus.sample) begin
                        if (w_onehot) begin
                            case (w_cls)
                                CLS_GT:  r_gt_cnt <= sat_inc(r_gt_cnt);
                                CLS_EQ:  r_eq_cnt <= sat_inc(r_eq_cnt);
                                CLS_LT:  r_lt_cnt <= sat_inc(r_lt_cnt);
                                default: ;
                            endcase
                            r_run_len <= (w_cls == r_last) ? sat_inc(r_run_len) : CNT_W'(1);
                            r_last    <= w_cls;
                        end else begin
                            r_state <= ST_ERR;
                            r_err   <= 1'b1;
                            r_busy  <= 1'b0;
                        end
                    end
                end
                ST_ERR: begin
                    // Frozen until clr/rst.
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.gt_cnt   = r_gt_cnt;
    assign bus.eq_cnt   = r_eq_cnt;
    assign bus.lt_cnt   = r_lt_cnt;
    assign bus.run_len  = r_run_len;
    assign bus.run_flag = (r_run_len >= RUN_TH_C);
    assign bus.err      = r_err;
    assign bus.busy     = r_busy;

endmodule

// File: tb/tb_cmp_result_monitor.sv
// tb_cmp_result_monitor
//   Drives two monitors (CNT_W=8/RUN_TH=4 and CNT_W=2/RUN_TH=2) with the same
//   stimulus and compares every output after every edge against a behavioural
//   model built from per-class tallies and a last-class/run-length pair.
module tb_cmp_result_monitor;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic en = 1'b0, clr = 1'b0, sample = 1'b0;
    logic [2:0] pat = 3'b000;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    cmp_result_monitor_if #(.CNT_W(8)) bus8 ();
    cmp_result_monitor_if #(.CNT_W(2)) bus2 ();

    assign bus8.en = en;  assign bus8.clr = clr;  assign bus8.sample = sample;
    assign bus8.f1 = pat[2]; assign bus8.f2 = pat[1]; assign bus8.f3 = pat[0];
    assign bus2.en = en;  assign bus2.clr = clr;  assign bus2.sample = sample;
    assign bus2.f1 = pat[2]; assign bus2.f2 = pat[1]; assign bus2.f3 = pat[0];

    cmp_result_monitor #(.CNT_W(8), .RUN_TH(4)) u_dut8 (
        .clk (clk),
        .rst (rst),
        .bus (bus8.slave)
    );

    cmp_result_monitor #(.CNT_W(2), .RUN_TH(2)) u_dut2 (
        .clk (clk),
        .rst (rst),
        .bus (bus2.slave)
    );

    // Behavioural model, one slot per instance.
    int  m_max[2] = '{255, 3};
    int  m_th[2]  = '{4, 2};
    bit  m_active[2];
    bit  m_fault[2];
    int  m_cnt[2][3];
    int  m_run[2];
    int  m_last[2];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_edge(input int k);
        int cls;
        if (rst || clr) begin
            m_active[k] = 0; m_fault[k] = 0;
            for (int c = 0; c < 3; c++) m_cnt[k][c] = 0;
            m_run[k] = 0; m_last[k] = -1;
        end else if (m_fault[k]) begin
            // frozen
        end else if (!m_active[k]) begin
            if (en) m_active[k] = 1;
        end else if (!en) begin
            m_active[k] = 0;
        end else if (sample) begin
            if ($countones(pat) == 1) begin
                cls = pat[2] ? 0 : (pat[1] ? 1 : 2);
                if (m_cnt[k][cls] < m_max[k]) m_cnt[k][cls]++;
                if (cls == m_last[k]) begin
                    if (m_run[k] < m_max[k]) m_run[k]++;
                end else begin
                    m_run[k] = 1;
                end
                m_last[k] = cls;
            end else begin
                m_fault[k] = 1;
                m_active[k] = 0;
            end
        end
    endtask

    task automatic check_all();
        check("w8_gt",   32'(bus8.gt_cnt),   32'(m_cnt[0][0]));
        check("w8_eq",   32'(bus8.eq_cnt),   32'(m_cnt[0][1]));
        check("w8_lt",   32'(bus8.lt_cnt),   32'(m_cnt[0][2]));
        check("w8_run",  32'(bus8.run_len),  32'(m_run[0]));
        check("w8_flag", 32'(bus8.run_flag), 32'(m_run[0] >= m_th[0]));
        check("w8_err",  32'(bus8.err),      32'(m_fault[0]));
        check("w8_busy", 32'(bus8.busy),     32'(m_active[0]));
        check("w2_gt",   32'(bus2.gt_cnt),   32'(m_cnt[1][0]));
        check("w2_eq",   32'(bus2.eq_cnt),   32'(m_cnt[1][1]));
        check("w2_lt",   32'(bus2.lt_cnt),   32'(m_cnt[1][2]));
        check("w2_run",  32'(bus2.run_len),  32'(m_run[1]));
        check("w2_flag", 32'(bus2.run_flag), 32'(m_run[1] >= m_th[1]));
        check("w2_err",  32'(bus2.err),      32'(m_fault[1]));
        check("w2_busy", 32'(bus2.busy),     32'(m_active[1]));
    endtask

    // Inputs are stable across the edge; model and DUT see the same values.
    task automatic step();
        @(posedge clk);
        model_edge(0);
        model_edge(1);
        #1;
        check_all();
    endtask

    task automatic cyc(input logic e, input logic c, input logic s, input logic [2:0] p);
        en = e; clr = c; sample = s; pat = p;
        step();
    endtask

    int eq_before;

    initial begin
        for (int k = 0; k < 2; k++) begin
            m_active[k] = 0; m_fault[k] = 0; m_run[k] = 0; m_last[k] = -1;
            for (int c = 0; c < 3; c++) m_cnt[k][c] = 0;
        end

        rst = 1'b1;
        step();
        step();
        check("rst_busy", 32'(bus8.busy), 32'd0);
        rst = 1'b0;

        // Run of four GT results.
        cyc(1, 0, 0, 3'b000);
        cyc(1, 0, 1, 3'b100);
        cyc(1, 0, 1, 3'b100);
        cyc(1, 0, 1, 3'b100);
        check("tp_gt3",   32'(bus8.gt_cnt),   32'd3);
        check("tp_run3",  32'(bus8.run_len),  32'd3);
        check("tp_flag0", 32'(bus8.run_flag), 32'd0);
        cyc(1, 0, 1, 3'b100);
        check("tp_flag1", 32'(bus8.run_flag), 32'd1);

        // Mixed classes.
        cyc(1, 1, 0, 3'b000);
        cyc(1, 0, 0, 3'b000);
        cyc(1, 0, 1, 3'b100);
        cyc(1, 0, 1, 3'b010);
        cyc(1, 0, 1, 3'b010);
        cyc(1, 0, 1, 3'b001);
        check("tp_mix_eq",  32'(bus8.eq_cnt),  32'd2);
        check("tp_mix_run", 32'(bus8.run_len), 32'd1);

        // Fault and recovery.
        cyc(1, 0, 1, 3'b110);
        check("tp_err", 32'(bus8.err), 32'd1);
        cyc(1, 0, 1, 3'b100);
        cyc(0, 0, 1, 3'b100);
        cyc(1, 0, 1, 3'b100);
        check("tp_err_gt", 32'(bus8.gt_cnt), 32'd1);
        cyc(1, 1, 0, 3'b000);
        check("tp_clr_err", 32'(bus8.err), 32'd0);
        cyc(1, 0, 0, 3'b000);
        check("tp_busy", 32'(bus8.busy), 32'd1);

        // Disabled strobes and the dropped IDLE->RUN sample.
        eq_before = int'(bus8.eq_cnt);
        cyc(0, 0, 1, 3'b010);
        cyc(0, 0, 1, 3'b010);
        cyc(1, 0, 1, 3'b010);
        cyc(1, 0, 1, 3'b010);
        check("tp_en_eq", 32'(bus8.eq_cnt), 32'(eq_before + 1));

        // Saturation on the narrow instance.
        cyc(1, 1, 0, 3'b000);
        cyc(1, 0, 0, 3'b000);
        for (int i = 0; i < 5; i++) cyc(1, 0, 1, 3'b001);
        check("tp_sat_lt",  32'(bus2.lt_cnt),  32'd3);
        check("tp_sat_run", 32'(bus2.run_len), 32'd3);
        cyc(1, 0, 1, 3'b100);
        check("tp_sat_gt",  32'(bus2.gt_cnt),  32'd1);
        check("tp_sat_r1",  32'(bus2.run_len), 32'd1);

        // clr beats a coincident strobe; rst mid-run.
        cyc(1, 1, 1, 3'b100);
        check("tp_clr_gt", 32'(bus8.gt_cnt), 32'd0);
        cyc(1, 0, 0, 3'b000);
        cyc(1, 0, 1, 3'b010);
        cyc(1, 0, 1, 3'b010);
        check("tp_pre_rst_run", 32'(bus8.run_len), 32'd2);
        rst = 1'b1;
        cyc(1, 0, 1, 3'b010);
        rst = 1'b0;
        check("tp_rst_run", 32'(bus8.run_len), 32'd0);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            int r;
            logic [2:0] p;
            r = int'($urandom_range(0, 99));
            if (r < 85)      p = 3'b001 << $urandom_range(0, 2);
            else             p = 3'($urandom_range(0, 7));
            rst = ($urandom_range(0, 199) == 0);
            cyc(($urandom_range(0, 9) != 0),
                ($urandom_range(0, 59) == 0),
                ($urandom_range(0, 9) < 7),
                p);
        end
        rst = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
